// File: rtl/riscv_loader_pkg.sv
// Shared types and stream-format constants for the picorv32 instruction loader.
package riscv_loader_pkg;

  localparam int PAYLOAD_BITS = 32;
  localparam logic [3:0] MAGIC = 4'hA;

  // Header word layout: {tag, reserved, word count}
  localparam int TAG_HI = 31;
  localparam int TAG_LO = 28;
  localparam int N_HI   = 23;
  localparam int N_LO   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BASE  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_e;

endpackage

// File: rtl/riscv_loader_byte_ser.sv
// Splits one 32-bit word into four little-endian byte writes on consecutive cycles,
// advancing a byte-address cursor that persists across words.
module riscv_loader_byte_ser #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_addr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              load,
  input  logic [31:0]       word,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        byte_data,
  output logic              wr_en,
  output logic              last
);

  logic [23:0] word_hi;
  logic [1:0]  idx;

  // High for the cycle that carries byte 3; the FSM leaves WRITE on this edge.
  assign last = wr_en & (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      byte_data <= '0;
      wr_en     <= 1'b0;
      word_hi   <= '0;
      idx       <= '0;
    end else if (load) begin
      word_hi   <= word[31:8];
      byte_data <= word[7:0];
      idx       <= 2'd0;
      wr_en     <= 1'b1;
    end else if (wr_en) begin
      addr <= addr + ADDR_W'(1);
      if (idx == 2'd3) begin
        wr_en <= 1'b0;
      end else begin
        byte_data <= word_hi[{idx, 3'b000} +: 8];
        idx       <= idx + 2'd1;
      end
    end else if (set_addr) begin
      addr <= base_addr;
    end
  end

endmodule

// File: rtl/riscv_instr_loader.sv
// Boot-time loader: receives a checksummed instruction image on a 32-bit stream,
// writes it byte-wise into picorv32 instruction memory, then releases the core.
module riscv_instr_loader #(
  parameter int         ADDR_W       = 24,
  parameter int         PAYLOAD_BITS = riscv_loader_pkg::PAYLOAD_BITS,
  parameter logic [3:0] MAGIC        = riscv_loader_pkg::MAGIC
) (
  input  logic                    clk_user,
  input  logic                    resetn,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    val_in,
  output logic                    ready_upward,
  input  logic                    ap_start,
  output logic [ADDR_W-1:0]       instr_config_addr,
  output logic [7:0]              instr_config_din,
  output logic                    instr_config_wr_en,
  output logic                    core_resetn,
  output logic                    load_done,
  output logic                    load_err,
  output logic [2:0]              dbg_state
);
  import riscv_loader_pkg::*;

  // Stream handshake: a word moves on a rising clk_user edge where val_in and
  // ready_upward are both high; ready_upward depends on state only, never on val_in.

  loader_state_e            state;
  logic                     rdy_en;
  logic [23:0]              n_reg;
  logic [23:0]              cnt;
  logic [PAYLOAD_BITS-1:0]  xor_r;
  logic                     xfer;
  logic                     hdr_ok;
  logic                     set_addr;
  logic                     ser_load;
  logic                     ser_last;

  // rdy_en holds ready low until the first edge after reset release.
  assign ready_upward = rdy_en & (state != ST_WRITE);
  assign xfer         = val_in & ready_upward;
  assign hdr_ok       = (din[TAG_HI:TAG_LO] == MAGIC);
  assign set_addr     = xfer & (state == ST_BASE);
  assign ser_load     = xfer & (state == ST_DATA);
  assign dbg_state    = state;

  riscv_loader_byte_ser #(
    .ADDR_W (ADDR_W)
  ) u_byte_ser (
    .clk       (clk_user),
    .rst_n     (resetn),
    .set_addr  (set_addr),
    .base_addr (din[ADDR_W-1:0]),
    .load      (ser_load),
    .word      (din),
    .addr      (instr_config_addr),
    .byte_data (instr_config_din),
    .wr_en     (instr_config_wr_en),
    .last      (ser_last)
  );

  always_ff @(posedge clk_user or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      rdy_en      <= 1'b0;
      n_reg       <= '0;
      cnt         <= '0;
      xor_r       <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      core_resetn <= 1'b0;
    end else begin
      rdy_en      <= 1'b1;
      core_resetn <= (state == ST_DONE) & ap_start;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (xfer) begin
            if (hdr_ok) begin
              n_reg     <= din[N_HI:N_LO];
              cnt       <= '0;
              xor_r     <= '0;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              state     <= ST_BASE;
            end else if (state == ST_IDLE) begin
              load_err <= 1'b1;
              state    <= ST_ERR;
            end
          end
        end
        ST_BASE: begin
          if (xfer) begin
            state <= (n_reg == 24'd0) ? ST_CHECK : ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            xor_r <= xor_r ^ din;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (ser_last) begin
            cnt   <= cnt + 24'd1;
            state <= (cnt + 24'd1 == n_reg) ? ST_CHECK : ST_DATA;
          end
        end
        ST_CHECK: begin
          if (xfer) begin
            if (din == xor_r) begin
              load_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              load_err <= 1'b1;
              state    <= ST_ERR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_instr_loader.sv
// Self-checking bench for riscv_instr_loader: stream driver, write scoreboard fed
// by an image-level model, and per-scenario tasks.
module tb_riscv_instr_loader;
  import riscv_loader_pkg::*;

  logic        clk_user = 1'b0;
  logic        resetn   = 1'b1;
  logic [31:0] din      = '0;
  logic        val_in   = 1'b0;
  logic        ap_start = 1'b0;
  logic        ready_upward;
  logic [23:0] instr_config_addr;
  logic [7:0]  instr_config_din;
  logic        instr_config_wr_en;
  logic        core_resetn;
  logic        load_done;
  logic        load_err;
  logic [2:0]  dbg_state;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [31:0] data_buf[16];
  bit          mon_en = 1'b0;

  riscv_instr_loader #(
    .ADDR_W       (24),
    .PAYLOAD_BITS (32),
    .MAGIC        (4'hA)
  ) dut (
    .clk_user           (clk_user),
    .resetn             (resetn),
    .din                (din),
    .val_in             (val_in),
    .ready_upward       (ready_upward),
    .ap_start           (ap_start),
    .instr_config_addr  (instr_config_addr),
    .instr_config_din   (instr_config_din),
    .instr_config_wr_en (instr_config_wr_en),
    .core_resetn        (core_resetn),
    .load_done          (load_done),
    .load_err           (load_err),
    .dbg_state          (dbg_state)
  );

  // Clock / watchdog
  always #5 clk_user = ~clk_user;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every byte write must match the head of the expected queue
  always @(negedge clk_user) begin
    if (resetn && mon_en && instr_config_wr_en) begin
      vectors++;
      if (ready_upward !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_during_write: ready_upward=%b required 0", ready_upward);
      end
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%h byte=%h required no write",
                 instr_config_addr, instr_config_din);
      end else begin
        exp_w = exp_q.pop_front();
        if ({instr_config_addr, instr_config_din} !== exp_w) begin
          miscompares++;
          $display("FAIL byte_write: addr/byte=%h/%h required %h/%h",
                   instr_config_addr, instr_config_din, exp_w[31:8], exp_w[7:0]);
        end
      end
    end
  end

  // Driver: offers one word, optionally with random gaps and val_in toggling
  task automatic send_word(input logic [31:0] w, input bit rnd);
    int guard;
    if (rnd) begin
      repeat ($urandom_range(0, 3)) begin
        val_in = 1'b0;
        @(negedge clk_user);
      end
    end
    din    = w;
    val_in = 1'b1;
    guard  = 0;
    while (!(ready_upward === 1'b1 && val_in === 1'b1) && guard < 64) begin
      @(negedge clk_user);
      guard++;
      val_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (guard >= 64) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word %h not accepted within 64 cycles, required acceptance", w);
    end
    @(negedge clk_user);
    val_in = 1'b0;
  endtask

  // Reference model: builds the image's expected byte writes, streams it, checks outcome
  task automatic run_load(input logic [23:0] n, input logic [23:0] base,
                          input logic [31:0] chk_flip, input bit rnd, input bit expect_drop);
    logic [31:0] chk;
    logic [23:0] a;
    bit          ok;
    chk = '0;
    for (int i = 0; i < int'(n); i++) begin
      chk = chk ^ data_buf[i];
      for (int k = 0; k < 4; k++) begin
        a = base + 24'(4 * i + k);
        exp_q.push_back({a, data_buf[i][8*k +: 8]});
      end
    end
    ok = (chk_flip == 32'd0);
    send_word({4'hA, 4'h0, n}, rnd);
    if (expect_drop) begin
      @(negedge clk_user);
      vectors++;
      if (core_resetn !== 1'b0) begin
        miscompares++;
        $display("FAIL reload_core_drop: core_resetn=%b required 0", core_resetn);
      end
    end
    send_word({8'($urandom), base}, rnd);
    for (int i = 0; i < int'(n); i++) send_word(data_buf[i], rnd);
    send_word(chk ^ chk_flip, rnd);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL writes_missing: %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (load_done !== ok) begin
      miscompares++;
      $display("FAIL load_done: got %b required %b", load_done, ok);
    end
    vectors++;
    if (load_err !== !ok) begin
      miscompares++;
      $display("FAIL load_err: got %b required %b", load_err, !ok);
    end
    vectors++;
    if (dbg_state !== (ok ? 3'(ST_DONE) : 3'(ST_ERR))) begin
      miscompares++;
      $display("FAIL end_state: got %0d required %0d", dbg_state, ok ? 5 : 6);
    end
    @(negedge clk_user);
    vectors++;
    if (core_resetn !== (ok & ap_start)) begin
      miscompares++;
      $display("FAIL core_resetn_after_load: got %b required %b", core_resetn, ok & ap_start);
    end
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    val_in   = 1'b0;
    ap_start = 1'b0;
    repeat (2) @(negedge clk_user);
    vectors++;
    if ({ready_upward, instr_config_addr, instr_config_din, instr_config_wr_en,
         core_resetn, load_done, load_err} !== '0 || dbg_state !== 3'(ST_IDLE)) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%b addr=%h din=%h we=%b core=%b done=%b err=%b st=%0d required all 0",
               ready_upward, instr_config_addr, instr_config_din, instr_config_wr_en,
               core_resetn, load_done, load_err, dbg_state);
    end
    resetn = 1'b1;
    vectors++;
    if (ready_upward !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: got %b required 0", ready_upward);
    end
    @(negedge clk_user);
    vectors++;
    if (ready_upward !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release: got %b required 1", ready_upward);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] w;
    w = $urandom;
    for (int k = 0; k < 4; k++) exp_q.push_back({24'h40 + 24'(k), w[8*k +: 8]});
    send_word(32'hA000_0002, 1'b0);
    send_word(32'h0000_0040, 1'b0);
    send_word(w, 1'b0);
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if ({ready_upward, instr_config_addr, instr_config_din, instr_config_wr_en,
         core_resetn, load_done, load_err} !== '0 || dbg_state !== 3'(ST_IDLE)) begin
      miscompares++;
      $display("FAIL mid_write_reset: rdy=%b addr=%h din=%h we=%b core=%b done=%b err=%b st=%0d required all 0",
               ready_upward, instr_config_addr, instr_config_din, instr_config_wr_en,
               core_resetn, load_done, load_err, dbg_state);
    end
    exp_q.delete();
    repeat (2) @(negedge clk_user);
    resetn = 1'b1;
    @(negedge clk_user);
    vectors++;
    if (ready_upward !== 1'b1 || core_resetn !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_write_release: rdy=%b core=%b required 1/0", ready_upward, core_resetn);
    end
  endtask

  task automatic test_basic_load();
    ap_start    = 1'b1;
    data_buf[0] = 32'h4433_2211;
    data_buf[1] = 32'h8877_6655;
    run_load(24'd2, 24'h000100, 32'd0, 1'b0, 1'b0);
    ap_start = 1'b0;
    @(negedge clk_user);
    vectors++;
    if (core_resetn !== 1'b0) begin
      miscompares++;
      $display("FAIL ap_start_fall: core_resetn=%b required 0", core_resetn);
    end
    ap_start = 1'b1;
    @(negedge clk_user);
    vectors++;
    if (core_resetn !== 1'b1) begin
      miscompares++;
      $display("FAIL ap_start_rise: core_resetn=%b required 1", core_resetn);
    end
  endtask

  task automatic test_discard_in_done();
    send_word(32'h1234_5678, 1'b0);
    @(negedge clk_user);
    vectors++;
    if (dbg_state !== 3'(ST_DONE) || load_done !== 1'b1 || core_resetn !== 1'b1) begin
      miscompares++;
      $display("FAIL done_discard: st=%0d done=%b core=%b required 5/1/1",
               dbg_state, load_done, core_resetn);
    end
  endtask

  task automatic test_checksum_fail();
    data_buf[0] = 32'h4433_2211;
    data_buf[1] = 32'h8877_6655;
    // Flip chosen so the sent checksum is zero
    run_load(24'd2, 24'h000100, 32'hCC44_4444, 1'b0, 1'b1);
  endtask

  task automatic test_bad_header();
    resetn = 1'b0;
    repeat (2) @(negedge clk_user);
    resetn = 1'b1;
    @(negedge clk_user);
    send_word(32'h5000_0001, 1'b0);
    vectors++;
    if (load_err !== 1'b1 || load_done !== 1'b0 || dbg_state !== 3'(ST_ERR)) begin
      miscompares++;
      $display("FAIL bad_header: err=%b done=%b st=%0d required 1/0/6", load_err, load_done, dbg_state);
    end
    send_word(32'h0000_0000, 1'b0);
    vectors++;
    if (dbg_state !== 3'(ST_ERR) || load_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_stays: st=%0d err=%b required 6/1", dbg_state, load_err);
    end
    for (int i = 0; i < 3; i++) data_buf[i] = $urandom;
    run_load(24'd3, 24'($urandom), 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_and_zero();
    data_buf[0] = 32'hDDCC_BBAA;
    run_load(24'd1, 24'hFFFFFE, 32'd0, 1'b0, 1'b1);
    run_load(24'd0, 24'($urandom), 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    bit          prev_ok;
    logic [31:0] flip;
    logic [23:0] n;
    prev_ok = 1'b1;
    for (int t = 0; t < 10; t++) begin
      n = 24'($urandom_range(1, 6));
      for (int i = 0; i < int'(n); i++) data_buf[i] = $urandom;
      flip = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : 32'd0;
      run_load(n, 24'($urandom), flip, 1'b1, prev_ok);
      prev_ok = (flip == 32'd0);
    end
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_reset_mid_write();
    test_basic_load();
    test_discard_in_done();
    test_checksum_fail();
    test_bad_header();
    test_wrap_and_zero();
    test_back_to_back();
    repeat (2) @(negedge clk_user);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
